// File: rtl/apb_bus_arbiter.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing and slave decode.
// Optional macro APB_PREADY_EN adds the Pready port and wait-state support in ACCESS.
module apb_bus_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned WIN_LOG2  = 26
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic [1:0]  req,
    input  logic        wr0,
    input  logic        wr1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic [1:0]  done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        Pwrite,
    output logic [2:0]  Pselx,
    output logic        Penable,
    output logic [31:0] Paddr,
    output logic [31:0] Pwdata,
    input  logic [31:0] Prdata
`ifdef APB_PREADY_EN
    ,
    input  logic        Pready
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]  state, nxt_state;
    logic        gnt, nxt_gnt;
    logic        last, nxt_last;
    logic [2:0]  nxt_pselx;
    logic        nxt_penable, nxt_pwrite;
    logic [31:0] nxt_paddr, nxt_pwdata;
    logic        complete;
    logic        grant_en, grant_id;

    // Addresses below the base or past the third window select no slave.
    function automatic logic [2:0] decode(input logic [31:0] a);
        logic [31:0] off;
        logic [31:0] idx;
        off = a - BASE_ADDR;
        idx = off >> WIN_LOG2;
        decode = 3'b000;
        if (a >= BASE_ADDR) begin
            case (idx)
                32'd0:   decode = 3'b001;
                32'd1:   decode = 3'b010;
                32'd2:   decode = 3'b100;
                default: decode = 3'b000;
            endcase
        end
    endfunction

    // Completion strobe; a reset landing on an ACCESS cycle abandons the transfer silently.
    always_comb begin
`ifdef APB_PREADY_EN
        complete = (state == ST_ACCESS) && Hresetn && (Pready || (Pselx == 3'b000));
`else
        complete = (state == ST_ACCESS) && Hresetn;
`endif
        done  = complete ? (gnt ? 2'b10 : 2'b01) : 2'b00;
        err   = complete && (Pselx == 3'b000);
        rdata = (complete && !Pwrite && !err) ? Prdata : 32'd0;
    end

    always_comb begin
        nxt_state   = state;
        nxt_gnt     = gnt;
        nxt_last    = last;
        nxt_pselx   = Pselx;
        nxt_penable = Penable;
        nxt_pwrite  = Pwrite;
        nxt_paddr   = Paddr;
        nxt_pwdata  = Pwdata;
        grant_en    = 1'b0;
        grant_id    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (|req) begin
                    grant_en = 1'b1;
                    grant_id = (&req) ? ~last : req[1];
                end
            end
            ST_SETUP: begin
                nxt_penable = 1'b1;
                nxt_state   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // The requester just served is excluded; only the other one can chain directly.
                if (complete) begin
                    if (req[~gnt]) begin
                        grant_en = 1'b1;
                        grant_id = ~gnt;
                    end else begin
                        nxt_state   = ST_IDLE;
                        nxt_pselx   = 3'b000;
                        nxt_penable = 1'b0;
                    end
                end
            end
            default: nxt_state = ST_IDLE;
        endcase

        if (grant_en) begin
            nxt_state   = ST_SETUP;
            nxt_gnt     = grant_id;
            nxt_last    = grant_id;
            nxt_penable = 1'b0;
            nxt_pwrite  = grant_id ? wr1 : wr0;
            nxt_paddr   = grant_id ? addr1 : addr0;
            nxt_pwdata  = grant_id ? wdata1 : wdata0;
            nxt_pselx   = decode(nxt_paddr);
        end
    end

    // last resets to 1 so the first contended grant goes to requester 0.
    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            state   <= ST_IDLE;
            gnt     <= 1'b0;
            last    <= 1'b1;
            Pselx   <= 3'b000;
            Penable <= 1'b0;
            Pwrite  <= 1'b0;
            Paddr   <= 32'd0;
            Pwdata  <= 32'd0;
        end else begin
            state   <= nxt_state;
            gnt     <= nxt_gnt;
            last    <= nxt_last;
            Pselx   <= nxt_pselx;
            Penable <= nxt_penable;
            Pwrite  <= nxt_pwrite;
            Paddr   <= nxt_paddr;
            Pwdata  <= nxt_pwdata;
        end
    end

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Randomized bench for apb_bus_arbiter against a transfer-level reference model.
// Honours APB_PREADY_EN when defined (random Pready wait states).
module tb_apb_bus_arbiter;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] WIN  = 32'h0400_0000;
    localparam int unsigned NCYC = 4000;

    logic        Hclk, Hresetn;
    logic [1:0]  req;
    logic        wr0, wr1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  done;
    logic        err;
    logic [31:0] rdata;
    logic        Pwrite, Penable;
    logic [2:0]  Pselx;
    logic [31:0] Paddr, Pwdata, Prdata;
`ifdef APB_PREADY_EN
    logic        Pready;
`endif

    apb_bus_arbiter dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .req(req),
        .wr0(wr0), .wr1(wr1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .done(done), .err(err), .rdata(rdata),
        .Pwrite(Pwrite), .Pselx(Pselx), .Penable(Penable),
        .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata)
`ifdef APB_PREADY_EN
        , .Pready(Pready)
`endif
    );

    initial begin
        Hclk = 1'b0;
        forever #5 Hclk = ~Hclk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Slave index is simply the window number counted from the base.
    function automatic logic [2:0] ref_sel(input logic [31:0] a);
        int unsigned idx;
        if (a < BASE) return 3'b000;
        idx = (a - BASE) / WIN;
        if (idx < 3) return 3'(1 << idx);
        return 3'b000;
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned k;
        logic [31:0] off;
        k   = $urandom_range(0, 7);
        off = $urandom & 32'h03ff_fffc;
        case (k)
            5:       return 32'h8c00_0000 + off;
            6:       return 32'h9000_0000 + off;
            7:       return $urandom & 32'h7fff_fffc;
            default: return BASE + (32'($urandom_range(0, 2)) << 26) + off;
        endcase
    endfunction

    task automatic new_payload(input int i);
        if (i == 0) begin
            wr0 = 1'($urandom_range(0, 1)); addr0 = rand_addr(); wdata0 = $urandom;
        end else begin
            wr1 = 1'($urandom_range(0, 1)); addr1 = rand_addr(); wdata1 = $urandom;
        end
    endtask

    // Reference model: at most one transfer in flight, described by who owns it,
    // its latched payload and how many cycles have elapsed since its SETUP cycle.
    bit          m_valid, m_id, m_last, m_zero, m_wr;
    int          m_age;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  m_done;
    int          n_served;

    task automatic start_xfer(input bit id);
        m_valid = 1'b1; m_id = id; m_age = 0; m_last = id; m_zero = 1'b0;
        m_wr    = id ? wr1 : wr0;
        m_addr  = id ? addr1 : addr0;
        m_wdata = id ? wdata1 : wdata0;
    endtask

    initial begin : main
        logic [2:0] exp_sel;
        logic [1:0] exp_done;
        bit         in_access, complete, exp_err;

        Hresetn = 1'b0;
        req     = 2'b11;
        new_payload(0);
        new_payload(1);
        Prdata  = $urandom;
`ifdef APB_PREADY_EN
        Pready  = 1'b1;
`endif
        m_valid = 1'b0; m_last = 1'b1; m_zero = 1'b1; m_done = 2'b00;
        n_served = 0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge Hclk);
            exp_sel   = m_valid ? ref_sel(m_addr) : 3'b000;
            in_access = m_valid && (m_age >= 1);
`ifdef APB_PREADY_EN
            complete  = in_access && Hresetn && ((exp_sel == 3'b000) || Pready);
`else
            complete  = in_access && Hresetn;
`endif
            exp_done  = complete ? (m_id ? 2'b10 : 2'b01) : 2'b00;
            exp_err   = complete && (exp_sel == 3'b000);

            check("Pselx",   32'(Pselx),   32'(exp_sel));
            check("Penable", 32'(Penable), 32'(in_access));
            check("done",    32'(done),    32'(exp_done));
            check("err",     32'(err),     32'(exp_err));
            if (m_valid || m_zero) begin
                check("Paddr",  Paddr,          m_valid ? m_addr : 32'd0);
                check("Pwrite", 32'(Pwrite),    m_valid ? 32'(m_wr) : 32'd0);
                check("Pwdata", Pwdata,         m_valid ? m_wdata : 32'd0);
            end
            if (complete) begin
                check("rdata", rdata, (!m_wr && !exp_err) ? Prdata : 32'd0);
                n_served++;
            end

            // Advance the model across the coming edge.
            if (!Hresetn) begin
                m_valid = 1'b0; m_last = 1'b1; m_zero = 1'b1;
            end else if (complete) begin
                if (req[~m_id]) start_xfer(~m_id);
                else m_valid = 1'b0;
            end else if (m_valid) begin
                m_age++;
            end else if (|req) begin
                start_xfer((req == 2'b11) ? ~m_last : req[1]);
            end
            m_done = exp_done;

            @(posedge Hclk);
            #1;
            Prdata = $urandom;
`ifdef APB_PREADY_EN
            Pready = ($urandom_range(0, 3) != 0);
`endif
            if (cyc < 2) begin
                Hresetn = 1'b0;
                req     = 2'b11;
            end else begin
                Hresetn = ($urandom_range(0, 99) >= 2);
                for (int i = 0; i < 2; i++) begin
                    if (m_done[i]) begin
                        if ($urandom_range(0, 2) == 0) new_payload(i);
                        else req[i] = 1'b0;
                    end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                        req[i] = 1'b1;
                        new_payload(i);
                    end
                end
            end
        end

        check("served_count", 32'(n_served > 200), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
